// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB and commit signal bundle for the reorder buffer.
// The ROB side uses the slave modport; dispatch/FUs/commit consumers use master.
interface reorder_buffer_if #(
  parameter int ROB_D = 8,
  parameter int CDB   = 2,
  parameter int ID_W  = $clog2(ROB_D)
);
  // dispatch
  logic                dispatch_valid;
  logic                dispatch_ready;
  logic [31:0]         dispatch_pc;
  logic [4:0]          dispatch_rd;
  logic                dispatch_has_rd;
  logic [ID_W-1:0]     dispatch_rob_id;
  // common data bus
  logic [CDB-1:0]      cdb_valid;
  logic [CDB*ID_W-1:0] cdb_rob_id;
  logic [CDB*32-1:0]   cdb_value;
  logic [CDB-1:0]      cdb_mispredict;
  // commit
  logic                commit_valid;
  logic [ID_W-1:0]     commit_rob_id;
  logic [4:0]          commit_rd;
  logic                commit_has_rd;
  logic [31:0]         commit_value;
  logic [31:0]         commit_pc;
  logic [63:0]         commit_order;
  logic                flush;
  logic                empty;

  modport master (
    output dispatch_valid, dispatch_pc, dispatch_rd, dispatch_has_rd,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict,
    input  dispatch_ready, dispatch_rob_id,
    input  commit_valid, commit_rob_id, commit_rd, commit_has_rd,
    input  commit_value, commit_pc, commit_order, flush, empty
  );

  modport slave (
    input  dispatch_valid, dispatch_pc, dispatch_rd, dispatch_has_rd,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict,
    output dispatch_ready, dispatch_rob_id,
    output commit_valid, commit_rob_id, commit_rd, commit_has_rd,
    output commit_value, commit_pc, commit_order, flush, empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at dispatch, captures CDB results,
// retires in program order one per cycle, flushes on a retired mispredict.
module reorder_buffer #(
  parameter int ROB_D = 8,
  parameter int CDB   = 2,
  parameter int ID_W  = $clog2(ROB_D)
) (
  input  logic              clk,
  input  logic              rst_n,
  reorder_buffer_if.slave   bus
);

  // pointers carry an extra wrap bit so full and empty are distinguishable
  logic [ID_W:0]   head_reg;
  logic [ID_W:0]   tail_reg;
  logic [63:0]     order_reg;

  logic [ID_W-1:0] head_idx;
  logic [ID_W-1:0] tail_idx;
  logic            full;
  logic            commit_fire;
  logic            flush_fire;
  logic            dispatch_fire;

  // per-entry state gathered from the generate blocks
  logic [ROB_D-1:0] valid_vec;
  logic [ROB_D-1:0] done_vec;
  logic [ROB_D-1:0] mis_vec;
  logic [ROB_D-1:0] has_rd_vec;
  logic [4:0]       rd_arr    [ROB_D];
  logic [31:0]      pc_arr    [ROB_D];
  logic [31:0]      value_arr [ROB_D];

  assign head_idx      = head_reg[ID_W-1:0];
  assign tail_idx      = tail_reg[ID_W-1:0];
  assign full          = (head_idx == tail_idx) && (head_reg[ID_W] != tail_reg[ID_W]);
  assign commit_fire   = valid_vec[head_idx] && done_vec[head_idx];
  assign flush_fire    = commit_fire && mis_vec[head_idx];
  assign dispatch_fire = bus.dispatch_valid && bus.dispatch_ready;

  // head/tail/order bookkeeping; a flush rewinds both pointers but keeps order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      order_reg <= '0;
    end else begin
      if (commit_fire) begin
        order_reg <= order_reg + 64'd1;
      end
      if (flush_fire) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (commit_fire) begin
          head_reg <= head_reg + 1'b1;
        end
        if (dispatch_fire) begin
          tail_reg <= tail_reg + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < ROB_D; gi++) begin : g_entry
    localparam logic [ID_W-1:0] IDX = ID_W'(gi);

    logic        cdb_hit;
    logic [31:0] cdb_val;
    logic        cdb_mis;
    logic        alloc;
    logic        retire;
    logic        valid_reg;
    logic        done_reg;
    logic        mis_reg;
    logic        has_rd_reg;
    logic [4:0]  rd_reg;
    logic [31:0] pc_reg;
    logic [31:0] value_reg;

    assign alloc  = dispatch_fire && (tail_idx == IDX);
    assign retire = commit_fire && (head_idx == IDX);

    // select the CDB port addressing this entry; higher port index wins
    always_comb begin
      cdb_hit = 1'b0;
      cdb_val = '0;
      cdb_mis = 1'b0;
      for (int p = 0; p < CDB; p++) begin
        if (bus.cdb_valid[p] && (bus.cdb_rob_id[p*ID_W +: ID_W] == IDX)) begin
          cdb_hit = 1'b1;
          cdb_val = bus.cdb_value[p*32 +: 32];
          cdb_mis = bus.cdb_mispredict[p];
        end
      end
    end

    // entry status: flush clears all, dispatch allocates, commit frees, CDB completes
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
        mis_reg   <= 1'b0;
      end else if (flush_fire) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
        mis_reg   <= 1'b0;
      end else if (alloc) begin
        valid_reg <= 1'b1;
        done_reg  <= 1'b0;
        mis_reg   <= 1'b0;
      end else if (retire) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
      end else if (valid_reg && cdb_hit) begin
        done_reg  <= 1'b1;
        mis_reg   <= cdb_mis;
      end
    end

    // payload storage; only observed while the entry is valid, so no reset
    always_ff @(posedge clk) begin
      if (alloc) begin
        pc_reg     <= bus.dispatch_pc;
        rd_reg     <= bus.dispatch_rd;
        has_rd_reg <= bus.dispatch_has_rd;
      end
      if (valid_reg && cdb_hit) begin
        value_reg <= cdb_val;
      end
    end

    assign valid_vec[gi]  = valid_reg;
    assign done_vec[gi]   = done_reg;
    assign mis_vec[gi]    = mis_reg;
    assign has_rd_vec[gi] = has_rd_reg;
    assign rd_arr[gi]     = rd_reg;
    assign pc_arr[gi]     = pc_reg;
    assign value_arr[gi]  = value_reg;
  end

  // dispatch side: ready uses registered full only, so same-cycle frees are not reused
  assign bus.dispatch_ready  = !full && !flush_fire;
  assign bus.dispatch_rob_id = tail_idx;

  // commit side: payload outputs are zero whenever nothing retires
  assign bus.commit_valid  = commit_fire;
  assign bus.commit_rob_id = head_idx;
  assign bus.commit_has_rd = commit_fire && has_rd_vec[head_idx];
  assign bus.commit_rd     = bus.commit_has_rd ? rd_arr[head_idx] : 5'd0;
  assign bus.commit_value  = commit_fire ? value_arr[head_idx] : 32'd0;
  assign bus.commit_pc     = commit_fire ? pc_arr[head_idx] : 32'd0;
  assign bus.commit_order  = commit_fire ? order_reg : 64'd0;
  assign bus.flush         = flush_fire;
  assign bus.empty         = (head_reg == tail_reg);

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer for the out-of-order RV32I core. Sits between dispatch (rename/RAT) and the register-file/RAT commit path, and consumes CDB broadcasts from the ALU and MUL functional units. It allocates a rob_id per dispatched instruction, records completion results, and retires in program order, one per cycle. It raises a flush on a committed branch mispredict.

Parameters:
ROB_D, 8, number of entries (power of two, ≥2)
CDB, 2, number of CDB write ports (N_ALU + N_MUL)
ID_W, $clog2(ROB_D), rob_id width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
dispatch_valid  in  1  dispatch offers an instruction
dispatch_ready  out  1  ROB can accept (not full and not flushing)
dispatch_pc  in  32  PC of instruction
dispatch_rd  in  5  architectural destination
dispatch_has_rd  in  1  instruction writes rd
dispatch_rob_id  out  ID_W  id the offered instruction receives (= tail index)
cdb_valid  in  CDB  per-port broadcast valid
cdb_rob_id  in  CDB*ID_W  per-port target id
cdb_value  in  CDB*32  per-port result
cdb_mispredict  in  CDB  per-port branch mispredict flag
commit_valid  out  1  head entry retires this cycle
commit_rob_id  out  ID_W  head index
commit_rd  out  5  destination (0 if !has_rd)
commit_has_rd  out  1  retiring instruction writes rd
commit_value  out  32  result value
commit_pc  out  32  PC of retiring instruction
commit_order  out  64  rvfi order of retiring instruction
flush  out  1  pipeline flush (mispredict retired)
empty  out  1  no valid entries

Behaviour:
- Storage per entry: valid, done, mispredict, has_rd, rd, pc, value.
- head/tail pointers are ID_W+1 bits (extra wrap bit). empty = (head == tail); full = index bits equal, wrap bits differ.
- Reset (async, rst_n low): head=tail=0, all valid/done=0, order counter=0. Outputs: dispatch_ready=1 once reset releases, commit_valid=0, flush=0, empty=1, other commit outputs 0. Reset mid-operation discards all entries immediately.
- Dispatch: dispatch_ready = !full && !flush. On dispatch_valid && dispatch_ready: write entry at tail (valid=1, done=0, mispredict=0), tail+1. dispatch_rob_id = tail index combinationally, valid regardless of handshake. A slot freed by commit in the same cycle is not reusable that cycle (ready depends only on registered full).
- CDB: for each port i with cdb_valid[i], if entry cdb_rob_id[i] is valid: set done=1, value=cdb_value[i], mispredict=cdb_mispredict[i]. Writes to invalid entries are ignored. Two ports targeting one id in the same cycle: higher port index wins (illegal upstream; not checked).
- Commit (combinational from registered state): commit_valid = entry[head].valid && entry[head].done. Minimum latency: CDB write in cycle M gives commit_valid in cycle M+1. When commit_valid: clear entry[head].valid, head+1, order counter+1. commit_order = counter value before increment. Max one commit per cycle.
- Flush: flush = commit_valid && entry[head].mispredict. In the flush cycle the mispredicting instruction still commits normally (outputs valid, order increments). On the next edge all entries are invalidated and head=tail=0. The order counter is preserved. Dispatch is blocked in the flush cycle; CDB writes in the flush cycle are discarded by the clear.
- Simultaneous dispatch + commit when not full: both take effect; occupancy unchanged.
- Pointers wrap modulo ROB_D on the index bits; the wrap bit toggles.

Test Plan:
- Reset: hold rst_n=0 mid-traffic → empty=1, commit_valid=0, flush=0, dispatch_rob_id=0; after release dispatch_ready=1.
- Fill: dispatch 8 with no CDB → ids 0..7 returned, dispatch_ready=0 after 8th, 9th offer not accepted, empty=0.
- Out-of-order completion: dispatch ids 0,1,2; CDB completes 2 (0x33), then 0 (0x11), then 1 (0x22) → commits in order 0,1,2 with values 0x11,0x22,0x33, commit_order 0,1,2, id 0 commits the cycle after its CDB write.
- Dual CDB: same cycle port0→id3=0xAAAA, port1→id4=0xBBBB after ids 0..2 done → consecutive commits of 3 then 4 with correct values.
- Mispredict flush: ids 0..4 in flight; id1 completes with mispredict=1, then id0 completes → commit id0, then id1 with flush=1; next cycle empty=1, ids 2..4 never commit, dispatch_rob_id=0, commit_order continues at 2.
- Wrap-around: 20 dispatch/complete/commit cycles, 3 in flight → ids wrap 7→0, full/empty correct, commit_order strictly increments 0..19.
